// File: rtl/qm_pkg.sv
// qm_pkg: shared opcode/funct constants, ALU op enum, branch encoding and reset PC for the qm pipeline
package qm_pkg;
  localparam logic [31:0] QM_RESET_PC = 32'hBFC0_0000;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [1:0] BR_NONE  = 2'b00;
  localparam logic [1:0] BR_EQ    = 2'b01;
  localparam logic [1:0] BR_NE    = 2'b10;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
  } alu_op_t;
endpackage

// File: rtl/qm_decode_ctl.sv
// qm_decode_ctl: combinational instruction -> control fields, immediate and source-use flags
//   in : instr
//   out: rs/rt (register fields), dst, alu_op, imm, use_imm (opb takes imm), shift (opa takes rt),
//        reg_we, mem_rd, mem_wr, br, use_rs/use_rt (hazard sources), illegal (QM_DECODE_ILLEGAL_EN only)
module qm_decode_ctl
  import qm_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  dst,
  output alu_op_t     alu_op,
  output logic [31:0] imm,
  output logic        use_imm,
  output logic        shift,
  output logic        reg_we,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [1:0]  br,
  output logic        use_rs,
  output logic        use_rt
`ifdef QM_DECODE_ILLEGAL_EN
  , output logic      illegal
`endif
);
  logic [5:0] op, fn;
  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  always_comb begin
    alu_op = ALU_ADD;
    imm = {{16{instr[15]}}, instr[15:0]};
    use_imm = 1'b0;
    shift = 1'b0;
    reg_we = 1'b0;
    dst = 5'd0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    br = BR_NONE;
    use_rs = 1'b1;
    use_rt = op == OP_RTYPE;
    case (op)
      OP_RTYPE: begin
        reg_we = 1'b1;
        dst = instr[15:11];
        case (fn)
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLL, FN_SRL: begin
            // shifts operate on rt with shamt carried as the B operand
            alu_op = fn == FN_SLL ? ALU_SLL : ALU_SRL;
            imm = {27'b0, instr[10:6]};
            use_imm = 1'b1;
            shift = 1'b1;
            use_rs = 1'b0;
          end
          default: begin
            reg_we = 1'b0;
            dst = 5'd0;
          end
        endcase
      end
      OP_ADDIU, OP_SLTI, OP_LW: begin
        alu_op = op == OP_SLTI ? ALU_SLT : ALU_ADD;
        use_imm = 1'b1;
        reg_we = 1'b1;
        dst = rt;
        mem_rd = op == OP_LW;
      end
      OP_ANDI, OP_ORI: begin
        alu_op = op == OP_ANDI ? ALU_AND : ALU_OR;
        imm = {16'h0, instr[15:0]};
        use_imm = 1'b1;
        reg_we = 1'b1;
        dst = rt;
      end
      OP_LUI: begin
        alu_op = ALU_LUI;
        imm = {instr[15:0], 16'h0};
        use_imm = 1'b1;
        reg_we = 1'b1;
        dst = rt;
        use_rs = 1'b0;
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        use_imm = 1'b1;
        use_rt = 1'b1;
        mem_wr = op == OP_SW;
        br = op == OP_BEQ ? BR_EQ : op == OP_BNE ? BR_NE : BR_NONE;
      end
      default: ;
    endcase
  end
`ifdef QM_DECODE_ILLEGAL_EN
  assign illegal = op == OP_RTYPE
    ? !(fn inside {FN_SLL, FN_SRL, FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_SLT})
    : !(op inside {OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE});
`endif
endmodule

// File: rtl/qm_decode.sv
// qm_decode: ID stage - decode, regfile read with WB bypass, load-use bubble, EX flush, ID/EX register
//   fetch in : if_valid, if_instr, if_pc; handshake out: id_ready
//   regfile  : rf_ra1/rf_ra2 out, rf_rd1/rf_rd2 in; writeback in: wb_we, wb_wa, wb_wd
//   EX in    : ex_ready, ex_flush; ID/EX out: de_valid, de_pc, de_opa, de_opb, de_rtval, de_dst,
//              de_reg_we, de_alu_op, de_mem_rd, de_mem_wr, de_br
//   QM_DECODE_ILLEGAL_EN adds de_illegal, flagging unsupported encodings (still issued as NOPs)
module qm_decode
  import qm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = QM_RESET_PC
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        id_ready,
  output logic [4:0]  rf_ra1,
  output logic [4:0]  rf_ra2,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  input  logic        wb_we,
  input  logic [4:0]  wb_wa,
  input  logic [31:0] wb_wd,
  input  logic        ex_ready,
  input  logic        ex_flush,
  output logic        de_valid,
  output logic [31:0] de_pc,
  output logic [31:0] de_opa,
  output logic [31:0] de_opb,
  output logic [31:0] de_rtval,
  output logic [4:0]  de_dst,
  output logic        de_reg_we,
  output logic [3:0]  de_alu_op,
  output logic        de_mem_rd,
  output logic        de_mem_wr,
  output logic [1:0]  de_br
`ifdef QM_DECODE_ILLEGAL_EN
  , output logic      de_illegal
`endif
);
  logic [4:0] rs, rt, dst;
  alu_op_t alu_op;
  logic [31:0] imm, rsval, rtval;
  logic use_imm, shift, reg_we, mem_rd, mem_wr, use_rs, use_rt, hazard;
  logic [1:0] br;
`ifdef QM_DECODE_ILLEGAL_EN
  logic illegal;
`endif
  qm_decode_ctl u_ctl (
    .instr(if_instr), .rs(rs), .rt(rt), .dst(dst), .alu_op(alu_op), .imm(imm),
    .use_imm(use_imm), .shift(shift), .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .br(br), .use_rs(use_rs), .use_rt(use_rt)
`ifdef QM_DECODE_ILLEGAL_EN
    , .illegal(illegal)
`endif
  );
  assign rf_ra1 = rs;
  assign rf_ra2 = rt;
  // the regfile writes at the edge, so a same-cycle writeback must be bypassed here
  assign rsval = rs == 5'd0 ? 32'd0 : (wb_we && wb_wa == rs) ? wb_wd : rf_rd1;
  assign rtval = rt == 5'd0 ? 32'd0 : (wb_we && wb_wa == rt) ? wb_wd : rf_rd2;
  assign hazard = if_valid && de_valid && de_mem_rd && de_dst != 5'd0 &&
                  ((use_rs && de_dst == rs) || (use_rt && de_dst == rt));
  assign id_ready = ex_ready && !hazard && !ex_flush;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      de_valid <= 1'b0;
      de_pc <= RESET_PC;
      de_opa <= '0;
      de_opb <= '0;
      de_rtval <= '0;
      de_dst <= '0;
      de_reg_we <= 1'b0;
      de_alu_op <= '0;
      de_mem_rd <= 1'b0;
      de_mem_wr <= 1'b0;
      de_br <= '0;
`ifdef QM_DECODE_ILLEGAL_EN
      de_illegal <= 1'b0;
`endif
    end else if (ex_flush || (ex_ready && (hazard || !if_valid))) begin
      de_valid <= 1'b0;
`ifdef QM_DECODE_ILLEGAL_EN
      de_illegal <= 1'b0;
`endif
    end else if (ex_ready) begin
      de_valid <= 1'b1;
      de_pc <= if_pc;
      de_opa <= shift ? rtval : rsval;
      de_opb <= use_imm ? imm : rtval;
      de_rtval <= rtval;
      de_dst <= dst;
      de_reg_we <= reg_we && dst != 5'd0;
      de_alu_op <= alu_op;
      de_mem_rd <= mem_rd;
      de_mem_wr <= mem_wr;
      de_br <= br;
`ifdef QM_DECODE_ILLEGAL_EN
      de_illegal <= illegal;
`endif
    end
  end
endmodule
